truth_table_sweeper: RTL and testbench

Sequencer that drives the 4-bit input space of a combinational function-under-test (x1..x4 -> f) through all 16 vectors, holds each for a programmable settle time, samples f, and assembles the 16-bit truth table. At the end of a sweep it compares the table against an expected pattern and reports the minterm count and the first mismatching index. It sits between a lab top-level or self-check harness and any 4-input combinational block, replacing hand-written exhaustive stimulus.

---
 rtl/truth_table_sweeper.sv | 88 ++++++++
 tb/tb_truth_table_sweeper.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 input vectors of a 4-input function, captures its truth table and checks it
// Ports: clk, rst_n (synchronous, active low); start/abort sweep control; f_in from the function under test;
//        expected reference table (bit i = f at vector i); x drives the function (x[3]=x1);
//        busy/done status; table_out, ones_count, match, mism_valid, mism_idx hold the last results
module truth_table_sweeper #(
   parameter int SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic        f_in,
   input  logic [15:0] expected,
   output logic [3:0]  x,
   output logic        busy,
   output logic        done,
   output logic [15:0] table_out,
   output logic [4:0]  ones_count,
   output logic        match,
   output logic        mism_valid,
   output logic [3:0]  mism_idx
);
   typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
   state_t state, state_nxt;
   logic [3:0] idx, wait_cnt, first_diff;
   logic [15:0] diff;
   logic active, accept, last;
   always_comb begin
      active = state == RUN || state == CHECK;
      accept = (state == IDLE || state == DONE) && start && !abort;
      // abort outranks the final sample of a vector
      last = state == RUN && !abort && wait_cnt == 4'(SETTLE - 1);
      diff = table_out ^ expected;
      // scan downward so the lowest differing index is the one that sticks
      first_diff = '0;
      for (int i = 15; i >= 0; i--)
         if (diff[i]) first_diff = 4'(i);
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = accept ? RUN : IDLE;
         RUN:        state_nxt = abort ? IDLE : (last && idx == 4'd15) ? CHECK : RUN;
         CHECK:      state_nxt = abort ? IDLE : DONE;
         default:    state_nxt = IDLE;
      endcase
      x = active ? idx : 4'd0;
      busy = active;
      done = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         wait_cnt <= '0;
         table_out <= '0;
         ones_count <= '0;
         match <= 1'b0;
         mism_valid <= 1'b0;
         mism_idx <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            idx <= '0;
            wait_cnt <= '0;
            table_out <= '0;
            ones_count <= '0;
            match <= 1'b0;
            mism_valid <= 1'b0;
            mism_idx <= '0;
         end else if (state == RUN && !abort) begin
            if (last) begin
               table_out[idx] <= f_in;
               ones_count <= ones_count + {4'd0, f_in};
               // idx stays at 15 into CHECK instead of wrapping
               if (idx != 4'd15) begin
                  idx <= idx + 4'd1;
                  wait_cnt <= '0;
               end
            end else begin
               wait_cnt <= wait_cnt + 4'd1;
            end
         end else if (state == CHECK && !abort) begin
            match <= diff == 16'd0;
            mism_valid <= |diff;
            mism_idx <= first_diff;
         end
      end
   end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench for the truth table sweeper (SETTLE=2 main instance, SETTLE=1 side instance)
module tb_truth_table_sweeper;
   localparam int S = 2;
   logic clk = 0, rst_n = 0, start = 0, abort = 0;
   logic [15:0] fut = 0, expected = 0;
   logic [3:0] x, mism_idx;
   logic busy, done, match, mism_valid, f_in;
   logic [15:0] table_out;
   logic [4:0] ones_count;
   logic start1 = 0;
   logic [15:0] fut1 = 0, exp1 = 0;
   logic [3:0] x1, mi1;
   logic busy1, done1, match1, mv1, f1;
   logic [15:0] tbl1;
   logic [4:0] ones1;
   int cyc = 0, errors = 0, checks = 0;

   typedef struct {
      logic [15:0] tbl;
      logic [4:0]  ones;
      logic        m;
      logic        mv;
      logic [3:0]  mi;
      int          when;
   } res_t;
   res_t sbq[$];

   assign f_in = fut[x];
   assign f1 = fut1[x1];

   truth_table_sweeper #(.SETTLE(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in), .expected(expected),
      .x(x), .busy(busy), .done(done), .table_out(table_out), .ones_count(ones_count),
      .match(match), .mism_valid(mism_valid), .mism_idx(mism_idx)
   );

   truth_table_sweeper #(.SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .f_in(f1), .expected(exp1),
      .x(x1), .busy(busy1), .done(done1), .table_out(tbl1), .ones_count(ones1),
      .match(match1), .mism_valid(mv1), .mism_idx(mi1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, act, req, cyc);
      end
   endtask

   function automatic res_t model(input logic [15:0] ft, input logic [15:0] ex, input int e0);
      res_t r;
      r.tbl = ft;
      r.ones = 5'($countones(ft));
      r.m = ft == ex;
      r.mv = ft != ex;
      r.mi = 0;
      for (int i = 15; i >= 0; i--)
         if (ft[i] != ex[i]) r.mi = 4'(i);
      r.when = e0 + 16 * S + 1;
      return r;
   endfunction

   function automatic logic [15:0] tt_of(input int kind);
      logic [15:0] t;
      logic [3:0] v;
      for (int i = 0; i < 16; i++) begin
         v = i[3:0];
         t[i] = kind == 0 ? ^v : kind == 1 ? &v : 1'b0;
      end
      return t;
   endfunction

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            res_t r;
            r = sbq.pop_front();
            chk("done_time", cyc, r.when);
            chk("table_out", table_out, r.tbl);
            chk("ones_count", ones_count, r.ones);
            chk("match", match, r.m);
            chk("mism_valid", mism_valid, r.mv);
            chk("mism_idx", mism_idx, r.mi);
         end
      end
   end

   task automatic check_reset_values(input string n);
      chk({n, "_x"}, x, 0);
      chk({n, "_busy"}, busy, 0);
      chk({n, "_done"}, done, 0);
      chk({n, "_table"}, table_out, 0);
      chk({n, "_ones"}, ones_count, 0);
      chk({n, "_match"}, match, 0);
      chk({n, "_mv"}, mism_valid, 0);
      chk({n, "_mi"}, mism_idx, 0);
   endtask

   // mode 0 normal, 1 stray start at edge 10, 2 abort at edge 12, 3 reset at idx 7
   task automatic sweep(input logic [15:0] ft, input logic [15:0] ex, input int mode);
      fut = ft;
      expected = ex;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      if (mode < 2) sbq.push_back(model(ft, ex, cyc));
      for (int k = 1; k <= 16 * S; k++) begin
         chk("run_x", x, (k - 1) / S);
         chk("run_busy", busy, 1);
         start = mode == 1 && k == 10;
         abort = mode == 2 && k == 12;
         rst_n = !(mode == 3 && k == 15);
         expected = k < 16 * S ? 16'($urandom) : ex;
         @(posedge clk); #1;
         if (mode == 2 && k == 12) begin
            abort = 0;
            chk("abort_x", x, 0);
            chk("abort_busy", busy, 0);
            chk("abort_match", match, 0);
            chk("abort_mv", mism_valid, 0);
            chk("abort_table", table_out, ft & 16'h001f);
            chk("abort_ones", ones_count, $countones(ft & 16'h001f));
            return;
         end
         if (mode == 3 && k == 15) begin
            rst_n = 1;
            check_reset_values("midreset");
            return;
         end
      end
      start = 0;
      chk("check_x", x, 15);
      chk("check_busy", busy, 1);
      @(posedge clk); #1;
      chk("done_x", x, 0);
      chk("done_busy", busy, 0);
      chk("done_pulse", done, 1);
      @(posedge clk); #1;
      chk("done_width", done, 0);
   endtask

   task automatic sweep1(input logic [15:0] ft, input logic [15:0] ex);
      int n = 0;
      res_t r;
      r = model(ft, ex, 0);
      fut1 = ft;
      exp1 = ex;
      start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      while (done1 !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("s1_latency", n, 17);
      chk("s1_table", tbl1, r.tbl);
      chk("s1_ones", ones1, r.ones);
      chk("s1_match", match1, r.m);
      chk("s1_mv", mv1, r.mv);
      chk("s1_mi", mi1, r.mi);
      @(posedge clk); #1;
      chk("s1_done_width", done1, 0);
   endtask

   initial begin
      logic [15:0] ft, ex;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      chk("reset_busy1", busy1, 0);
      rst_n = 1;
      @(posedge clk); #1;

      sweep(tt_of(0), 16'h6996, 0);
      sweep(tt_of(1), 16'h0000, 0);
      sweep(tt_of(2), 16'h0000, 0);
      sweep(tt_of(0), 16'h6996, 1);
      sweep(tt_of(0), 16'h6996, 2);
      repeat (40) @(posedge clk);
      #1;
      chk("idle_after_abort_x", x, 0);
      chk("idle_after_abort_busy", busy, 0);
      sweep(tt_of(1), 16'h8000, 0);
      sweep(tt_of(0), 16'h6996, 3);
      sweep(tt_of(0), 16'h6996, 0);

      // start held high: two sweeps back to back
      fut = tt_of(0);
      expected = 16'h6996;
      start = 1;
      @(posedge clk); #1;
      sbq.push_back(model(fut, expected, cyc));
      sbq.push_back(model(fut, expected, cyc + 16 * S + 2));
      repeat (2 * (16 * S + 2) - 3) @(posedge clk);
      #1;
      start = 0;
      repeat (6) @(posedge clk);
      #1;

      for (int t = 0; t < 10; t++) begin
         ft = 16'($urandom);
         case ($urandom_range(0, 2))
            0: ex = ft;
            1: ex = ft ^ (16'd1 << $urandom_range(0, 15));
            default: ex = 16'($urandom);
         endcase
         sweep(ft, ex, 0);
      end

      // abort and start together while idle: abort wins
      start = 1;
      abort = 1;
      @(posedge clk); #1;
      start = 0;
      abort = 0;
      chk("abort_start_idle_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_start_idle_busy2", busy, 0);

      sweep1(16'h0000, 16'h0000);
      sweep1(16'($urandom), 16'($urandom));

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
